// File: rtl/fpcdiv_vrtl_if.sv
// Operand/result handshake bundle for the fixed-point complex divider.
// master drives operands and consumes results; slave is the divider.
interface fpcdiv_vrtl_if #(
    parameter int n = 32
);
    logic         recv_val;
    logic         recv_rdy;
    logic         send_val;
    logic         send_rdy;
    logic [n-1:0] ar;
    logic [n-1:0] ac;
    logic [n-1:0] br;
    logic [n-1:0] bc;
    logic [n-1:0] cr;
    logic [n-1:0] cc;
    logic         dbz;

    modport master (
        output recv_val, ar, ac, br, bc, send_rdy,
        input  recv_rdy, send_val, cr, cc, dbz
    );

    modport slave (
        input  recv_val, ar, ac, br, bc, send_rdy,
        output recv_rdy, send_val, cr, cc, dbz
    );
endinterface

// File: rtl/fpcdiv_vrtl.sv
// Iterative fixed-point complex divider c = a / b on one shift-add multiplier and one restoring divider.
// Define FPCDIV_SATURATE_EN to clamp overflowing quotients instead of wrapping them.
module fpcdiv_vrtl #(
    parameter int n = 32,
    parameter int d = 16
) (
    input  logic         clk,
    input  logic         reset,
    fpcdiv_vrtl_if.slave io
);
    localparam int W2 = 2 * n;
    localparam int QW = n + d;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    // latched operands
    logic [n-1:0]  ar_q, ac_q, br_q, bc_q;

    // shared multiplier
    logic [W2-1:0] mcand, acc, acc_nxt, term;
    logic [n-1:0]  mplier;
    logic [2:0]    pidx;
    logic [CW-1:0] cnt;
    logic [n-1:0]  prod;
    logic [n-1:0]  num_r, num_i, den, den_sum;
    logic [n-1:0]  x_nxt, y_nxt;
    logic          mul_last, mul_done;

    // shared divider
    logic [QW-1:0] dq, dq_nxt;
    logic [n-1:0]  rem, rem_nxt, dvsr;
    logic [n:0]    rem_sh, trial;
    logic          qbit, q_neg, den_neg, div_sel, div_last;
    logic [n-1:0]  q_res;

    // results
    logic [n-1:0]  cr_q, cc_q;
    logic          dbz_q;

    function automatic logic [n-1:0] mag(input logic [n-1:0] v);
        return v[n-1] ? (~v + 1'b1) : v;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (io.recv_val)           state_nxt = MUL;
            MUL:  if (mul_done)              state_nxt = (den_sum == '0) ? DONE : DIV;
            DIV:  if (div_last && div_sel)   state_nxt = DONE;
            DONE: if (io.send_rdy)           state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        io.recv_rdy = (state == IDLE);
        io.send_val = (state == DONE);
    end

    assign io.cr  = cr_q;
    assign io.cc  = cc_q;
    assign io.dbz = dbz_q;

    // ---------------- multiplier step ----------------
    // The multiplier MSB carries negative weight, so the final partial product is subtracted.
    always_comb begin
        term     = mplier[0] ? mcand : '0;
        mul_last = (cnt == CW'(n - 1));
        acc_nxt  = mul_last ? (acc - term) : (acc + term);
        prod     = acc_nxt[n+d-1:d];
        den_sum  = den + prod;
        mul_done = (state == MUL) && mul_last && (pidx == 3'd5);
    end

    // operands for the product that follows the current one
    always_comb begin
        x_nxt = bc_q;
        y_nxt = bc_q;
        case (pidx)
            3'd0:    begin x_nxt = ac_q; y_nxt = bc_q; end
            3'd1:    begin x_nxt = ac_q; y_nxt = br_q; end
            3'd2:    begin x_nxt = ar_q; y_nxt = bc_q; end
            3'd3:    begin x_nxt = br_q; y_nxt = br_q; end
            default: begin x_nxt = bc_q; y_nxt = bc_q; end
        endcase
    end

    // ---------------- divider step ----------------
    always_comb begin
        rem_sh   = {rem, dq[QW-1]};
        trial    = rem_sh - {1'b0, dvsr};
        qbit     = ~trial[n];
        rem_nxt  = qbit ? trial[n-1:0] : rem_sh[n-1:0];
        dq_nxt   = {dq[QW-2:0], qbit};
        div_last = (cnt == CW'(QW - 1));
    end

    // signed quotient from the completed magnitude
    always_comb begin
        q_res = q_neg ? (~dq_nxt[n-1:0] + 1'b1) : dq_nxt[n-1:0];
`ifdef FPCDIV_SATURATE_EN
        if (!q_neg && (|dq_nxt[QW-1:n-1]))
            q_res = {1'b0, {(n-1){1'b1}}};
        else if (q_neg && ((|dq_nxt[QW-1:n]) || (dq_nxt[n-1] && (|dq_nxt[n-2:0]))))
            q_res = {1'b1, {(n-1){1'b0}}};
`endif
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cr_q    <= '0;
            cc_q    <= '0;
            dbz_q   <= 1'b0;
            cnt     <= '0;
            pidx    <= '0;
            div_sel <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (io.recv_val) begin
                        ar_q   <= io.ar;
                        ac_q   <= io.ac;
                        br_q   <= io.br;
                        bc_q   <= io.bc;
                        mcand  <= {{n{io.ar[n-1]}}, io.ar};
                        mplier <= io.br;
                        acc    <= '0;
                        cnt    <= '0;
                        pidx   <= '0;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        acc    <= '0;
                        cnt    <= '0;
                        pidx   <= pidx + 3'd1;
                        mcand  <= {{n{x_nxt[n-1]}}, x_nxt};
                        mplier <= y_nxt;
                        case (pidx)
                            3'd0:    num_r <= prod;
                            3'd1:    num_r <= num_r + prod;
                            3'd2:    num_i <= prod;
                            3'd3:    num_i <= num_i - prod;
                            3'd4:    den   <= prod;
                            default: den   <= den_sum;
                        endcase
                        if (pidx == 3'd5) begin
                            if (den_sum == '0) begin
                                cr_q  <= '0;
                                cc_q  <= '0;
                                dbz_q <= 1'b1;
                            end else begin
                                dbz_q   <= 1'b0;
                                dq      <= {mag(num_r), {d{1'b0}}};
                                dvsr    <= mag(den_sum);
                                rem     <= '0;
                                q_neg   <= num_r[n-1] ^ den_sum[n-1];
                                den_neg <= den_sum[n-1];
                                div_sel <= 1'b0;
                            end
                        end
                    end else begin
                        acc    <= acc_nxt;
                        cnt    <= cnt + 1'b1;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                DIV: begin
                    if (div_last) begin
                        cnt <= '0;
                        if (!div_sel) begin
                            // real part finished; reload the same divider for the imaginary part
                            cr_q    <= q_res;
                            div_sel <= 1'b1;
                            dq      <= {mag(num_i), {d{1'b0}}};
                            rem     <= '0;
                            q_neg   <= num_i[n-1] ^ den_neg;
                        end else begin
                            cc_q <= q_res;
                        end
                    end else begin
                        dq  <= dq_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpcdiv_vrtl.sv
// Self-checking bench for fpcdiv_vrtl: directed cases, backpressure, mid-op reset, random ops vs. arithmetic model.
// Honours FPCDIV_SATURATE_EN the same way as the design.
module tb_fpcdiv_vrtl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpcdiv_vrtl_if #(.n(32)) io ();

    fpcdiv_vrtl #(.n(32), .d(16)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_prod(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_quot(input logic [31:0] num, input logic [31:0] den);
        logic [63:0] mn, md, q;
        logic [31:0] lo;
        bit neg;
        mn  = {32'd0, num[31] ? (32'd0 - num) : num};
        md  = {32'd0, den[31] ? (32'd0 - den) : den};
        q   = (mn << 16) / md;
        neg = num[31] ^ den[31];
        lo  = q[31:0];
`ifdef FPCDIV_SATURATE_EN
        if (!neg && q > 64'h7FFF_FFFF) return 32'h7FFF_FFFF;
        if (neg && q > 64'h8000_0000) return 32'h8000_0000;
`endif
        return neg ? (32'd0 - lo) : lo;
    endfunction

    task automatic model(input logic [31:0] a_r, a_c, b_r, b_c,
                         output logic [31:0] e_cr, e_cc, output logic e_dbz, output int e_lat);
        logic [31:0] nr, ni, dn;
        nr = m_prod(a_r, b_r) + m_prod(a_c, b_c);
        ni = m_prod(a_c, b_r) - m_prod(a_r, b_c);
        dn = m_prod(b_r, b_r) + m_prod(b_c, b_c);
        if (dn == 32'd0) begin
            e_cr = 32'd0; e_cc = 32'd0; e_dbz = 1'b1; e_lat = 192;
        end else begin
            e_cr = m_quot(nr, dn); e_cc = m_quot(ni, dn); e_dbz = 1'b0; e_lat = 288;
        end
    endtask

    // ---------------- drivers (time is always posedge+1 between calls) ----------------
    task automatic start_op(input logic [31:0] a_r, a_c, b_r, b_c, output bit ok);
        int waited = 0;
        io.ar = a_r; io.ac = a_c; io.br = b_r; io.bc = b_c;
        io.recv_val = 1'b1;
        ok = 1'b1;
        while (io.recv_rdy !== 1'b1) begin
            if (waited >= 1000) begin ok = 1'b0; break; end
            @(posedge clk); #1; waited++;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        io.recv_val = 1'b0;
        // operands changing after the accept edge must not matter
        io.ar = $urandom; io.ac = $urandom; io.br = $urandom; io.bc = $urandom;
    endtask

    task automatic wait_result(output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b0;
        while (io.send_val !== 1'b1) begin
            if (lat >= 1000) begin timed_out = 1'b1; break; end
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op();
        io.send_rdy = 1'b1;
        @(posedge clk); #1;
        io.send_rdy = 1'b0;
    endtask

    task automatic recover();
        io.recv_val = 1'b0; io.send_rdy = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val(input int mode);
        logic [31:0] v;
        case (mode)
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            2:       v = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
            default: v = 32'($urandom_range(0, 32'h0000_4000)) - 32'h0000_2000;
        endcase
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        io.recv_val = 1'b0; io.send_rdy = 1'b0;
        io.ar = '0; io.ac = '0; io.br = '0; io.bc = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (io.recv_rdy !== 1'b1 || io.send_val !== 1'b0 || io.cr !== 32'd0 ||
            io.cc !== 32'd0 || io.dbz !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b val=%b cr=%h cc=%h dbz=%b expected rdy=1 val=0 cr=0 cc=0 dbz=0",
                     io.recv_rdy, io.send_val, io.cr, io.cc, io.dbz);
        end
    endtask

    task automatic test_directed();
        logic [31:0] t_ar [4], t_ac [4], t_br [4], t_bc [4], x_cr [4], x_cc [4];
        logic        x_dbz [4];
        int          x_lat [4];
        int lat; bit ok, to;
        t_ar = '{32'h0002_0000, 32'hFFFF_0000, 32'h1234_5678, 32'h7FFF_0000};
        t_ac = '{32'h0004_0000, 32'h0000_0000, 32'h0BAD_0000, 32'h0000_0000};
        t_br = '{32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100};
        t_bc = '{32'h0001_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000};
        x_cc = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000};
        x_cr[0] = 32'h0003_0000; x_cr[1] = 32'h0; x_cr[2] = 32'h0;
`ifdef FPCDIV_SATURATE_EN
        x_cr[3] = 32'h7FFF_FFFF;
`else
        x_cr[3] = 32'hFF00_0000;
`endif
        x_dbz = '{1'b0, 1'b0, 1'b1, 1'b0};
        x_lat = '{288, 288, 192, 288};
        for (int i = 0; i < 4; i++) begin
            start_op(t_ar[i], t_ac[i], t_br[i], t_bc[i], ok);
            wait_result(lat, to);
            checks++;
            if (!ok || to) begin
                failures++;
                $display("FAIL directed%0d handshake: got accept=%b timeout=%b expected accept=1 timeout=0", i, ok, to);
                recover();
                continue;
            end
            checks++;
            if (lat !== x_lat[i]) begin failures++; $display("FAIL directed%0d latency: got %0d expected %0d", i, lat, x_lat[i]); end
            checks++;
            if (io.cr !== x_cr[i]) begin failures++; $display("FAIL directed%0d cr: got %h expected %h", i, io.cr, x_cr[i]); end
            checks++;
            if (io.cc !== x_cc[i]) begin failures++; $display("FAIL directed%0d cc: got %h expected %h", i, io.cc, x_cc[i]); end
            checks++;
            if (io.dbz !== x_dbz[i]) begin failures++; $display("FAIL directed%0d dbz: got %b expected %b", i, io.dbz, x_dbz[i]); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat; bit ok, to;
        start_op(32'h0002_0000, 32'h0004_0000, 32'h0001_0000, 32'h0001_0000, ok);
        wait_result(lat, to);
        checks++;
        if (!ok || to) begin
            failures++;
            $display("FAIL backpressure handshake: got accept=%b timeout=%b expected accept=1 timeout=0", ok, to);
            recover();
            return;
        end
        for (int c = 0; c < 10; c++) begin
            io.recv_val = 1'b1;
            io.ar = $urandom; io.ac = $urandom; io.br = $urandom; io.bc = $urandom;
            @(posedge clk); #1;
            checks++;
            if (io.send_val !== 1'b1 || io.recv_rdy !== 1'b0 || io.cr !== 32'h0003_0000 ||
                io.cc !== 32'h0001_0000 || io.dbz !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold%0d: got val=%b rdy=%b cr=%h cc=%h dbz=%b expected val=1 rdy=0 cr=00030000 cc=00010000 dbz=0",
                         c, io.send_val, io.recv_rdy, io.cr, io.cc, io.dbz);
            end
        end
        io.recv_val = 1'b0;
        finish_op();
        checks++;
        if (io.recv_rdy !== 1'b1 || io.send_val !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got rdy=%b val=%b expected rdy=1 val=0", io.recv_rdy, io.send_val);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; bit ok, to;
        start_op(32'hFFFF_0000, 32'h0, 32'h0, 32'h0002_0000, ok);
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (io.recv_rdy !== 1'b1 || io.send_val !== 1'b0 || io.cr !== 32'd0 || io.cc !== 32'd0 || io.dbz !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: got rdy=%b val=%b cr=%h cc=%h dbz=%b expected rdy=1 val=0 cr=0 cc=0 dbz=0",
                     io.recv_rdy, io.send_val, io.cr, io.cc, io.dbz);
        end
        start_op(32'h0002_0000, 32'h0004_0000, 32'h0001_0000, 32'h0001_0000, ok);
        wait_result(lat, to);
        checks++;
        if (!ok || to || lat !== 288 || io.cr !== 32'h0003_0000 || io.cc !== 32'h0001_0000 || io.dbz !== 1'b0) begin
            failures++;
            $display("FAIL midop_followup: got ok=%b to=%b lat=%0d cr=%h cc=%h dbz=%b expected ok=1 to=0 lat=288 cr=00030000 cc=00010000 dbz=0",
                     ok, to, lat, io.cr, io.cc, io.dbz);
            if (!ok || to) begin recover(); return; end
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [31:0] a_r, a_c, b_r, b_c, e_cr, e_cc;
        logic e_dbz;
        int e_lat, lat;
        bit ok, to;
        for (int k = 0; k < 24; k++) begin
            a_r = rnd_val($urandom_range(0, 3));
            a_c = rnd_val($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                b_r = rnd_val(3) & 32'h0000_00FF;
                b_c = 32'd0;
            end else begin
                b_r = rnd_val($urandom_range(0, 3));
                b_c = rnd_val($urandom_range(0, 3));
            end
            model(a_r, a_c, b_r, b_c, e_cr, e_cc, e_dbz, e_lat);
            start_op(a_r, a_c, b_r, b_c, ok);
            wait_result(lat, to);
            checks++;
            if (!ok || to) begin
                failures++;
                $display("FAIL random%0d handshake: got accept=%b timeout=%b expected accept=1 timeout=0", k, ok, to);
                recover();
                continue;
            end
            checks++;
            if (lat !== e_lat) begin failures++; $display("FAIL random%0d latency: got %0d expected %0d", k, lat, e_lat); end
            checks++;
            if (io.cr !== e_cr) begin failures++; $display("FAIL random%0d cr: a=%h+j%h b=%h+j%h got %h expected %h", k, a_r, a_c, b_r, b_c, io.cr, e_cr); end
            checks++;
            if (io.cc !== e_cc) begin failures++; $display("FAIL random%0d cc: a=%h+j%h b=%h+j%h got %h expected %h", k, a_r, a_c, b_r, b_c, io.cc, e_cc); end
            checks++;
            if (io.dbz !== e_dbz) begin failures++; $display("FAIL random%0d dbz: got %b expected %b", k, io.dbz, e_dbz); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            finish_op();
        end
    endtask

    initial begin
        io.recv_val = 1'b0;
        io.send_rdy = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
